// File: rtl/div_seq_ctrl_if.sv
`default_nettype none
// ==========================================================================
// div_seq_ctrl_if : host start/done handshake and operand/result bus of the divider (dbz under DIV_DBZ_ERR_EN)
// Revision 1.0
// ==========================================================================
interface div_seq_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
`ifdef DIV_DBZ_ERR_EN
  logic             dbz;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, dbz
  );
  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, dbz
  );
`else
  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder
  );
  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder
  );
`endif
endinterface
`default_nettype wire

// File: rtl/div_seq_ctrl.sv
`default_nettype none
// ==========================================================================
// div_seq_ctrl : restoring-division controller, one quotient bit per clock over a shared FS ripple chain
// Revision 1.0 -- optional divide-by-zero fast path and dbz flag under DIV_DBZ_ERR_EN
// ==========================================================================
module div_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input wire            clk,
  input wire            rst_n,
  div_seq_ctrl_if.slave bus
);

  localparam int              c_CW   = $clog2(WIDTH + 1);
  localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);
  localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_RUN  = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [c_CW-1:0]  count_q, count_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] dreg_q, dreg_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             done_q, done_d;

  logic w_busy, w_load, w_iter, w_fin, w_dz;

`ifdef DIV_DBZ_ERR_EN
  logic dbz_q, dbz_d;
  assign w_dz = (bus.divisor == '0);
`else
  assign w_dz = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= c_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_IDLE:  if (bus.start) state_d = w_dz ? c_DONE : c_RUN;
      c_RUN:   if (count_q == c_LAST) state_d = c_DONE;
      c_DONE:  state_d = c_IDLE;
      default: state_d = c_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    w_busy = 1'b0;
    w_load = 1'b0;
    w_iter = 1'b0;
    w_fin  = 1'b0;
    case (state_q)
      c_IDLE:  w_load = bus.start;
      c_RUN:   begin w_busy = 1'b1; w_iter = 1'b1; end
      c_DONE:  begin w_busy = 1'b1; w_fin  = 1'b1; end
      default: ;
    endcase
  end

  // The partial remainder stays below the divisor, so the top bit of the
  // (WIDTH+1)-bit A is always zero and only its borrow is formed in the chain.
  logic [WIDTH:0]   w_opa, w_opb;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH+1:0] w_bor;
  logic             w_sign;

  assign w_opa    = {a_q, q_q[WIDTH-1]};
  assign w_opb    = {1'b0, dreg_q};
  assign w_bor[0] = 1'b0;

  for (genvar i = 0; i <= WIDTH; i++) begin : g_fs
    assign w_bor[i+1] = (~w_opa[i] & w_bor[i]) | (~w_opa[i] & w_opb[i]) | (w_opb[i] & w_bor[i]);
    if (i < WIDTH) begin : g_diff
      assign w_diff[i] = w_opa[i] ^ w_opb[i] ^ w_bor[i];
    end
  end

  assign w_sign = w_bor[WIDTH+1];

  always_comb begin
    a_d     = a_q;
    q_d     = q_q;
    dreg_d  = dreg_q;
    count_d = count_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
`ifdef DIV_DBZ_ERR_EN
    dbz_d   = dbz_q;
`endif
    if (w_load) begin
      a_d     = '0;
      q_d     = bus.dividend;
      dreg_d  = bus.divisor;
      count_d = '0;
`ifdef DIV_DBZ_ERR_EN
      dbz_d   = 1'b0;
      // Preload the final D=0 results so DONE handles both paths uniformly.
      if (w_dz) begin
        q_d = '1;
        a_d = bus.dividend;
      end
`endif
    end
    if (w_iter) begin
      a_d     = w_sign ? w_opa[WIDTH-1:0] : w_diff;
      q_d     = {q_q[WIDTH-2:0], ~w_sign};
      count_d = count_q + c_ONE;
    end
    if (w_fin) begin
      quo_d  = q_q;
      rem_d  = a_q;
      done_d = 1'b1;
`ifdef DIV_DBZ_ERR_EN
      dbz_d  = (dreg_q == '0);
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      q_q     <= '0;
      dreg_q  <= '0;
      count_q <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      a_q     <= a_d;
      q_q     <= q_d;
      dreg_q  <= dreg_d;
      count_q <= count_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
    end
  end

`ifdef DIV_DBZ_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbz_q <= 1'b0;
    end else begin
      dbz_q <= dbz_d;
    end
  end
  assign bus.dbz = dbz_q;
`endif

  assign bus.busy      = w_busy;
  assign bus.done      = done_q;
  assign bus.quotient  = quo_q;
  assign bus.remainder = rem_q;

endmodule
`default_nettype wire

// File: tb/tb_div_seq_ctrl.sv
`default_nettype none
// ==========================================================================
// tb_div_seq_ctrl : directed and random back-to-back divisions checked against N/D, N%D (honours DIV_DBZ_ERR_EN)
// Revision 1.0
// ==========================================================================
module tb_div_seq_ctrl;

  localparam int WIDTH = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   prev_q   = 0;
  int   prev_r   = 0;

  div_seq_ctrl_if #(.WIDTH(WIDTH)) bus ();

  div_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_q(input int n, input int d);
    return (d == 0) ? ((1 << WIDTH) - 1) : n / d;
  endfunction

  function automatic int exp_r(input int n, input int d);
    return (d == 0) ? n : n % d;
  endfunction

  function automatic int exp_lat(input int d);
`ifdef DIV_DBZ_ERR_EN
    if (d == 0) return 1;
`endif
    return WIDTH + 1;
  endfunction

  // One handshake: pulse start, then watch done for latency, hold and result.
  task automatic run_div(input int n, input int d, input bit disturb);
    int cyc;
    bit seen;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = n[WIDTH-1:0];
    bus.divisor  = d[WIDTH-1:0];
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("busy_after_start", bus.busy, 1);
`ifdef DIV_DBZ_ERR_EN
    check("dbz_clear_on_start", bus.dbz, 0);
`endif
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 30) begin
      if (disturb && cyc == 2) begin
        bus.start    = 1'b1;
        bus.dividend = 8'($urandom);
        bus.divisor  = 8'($urandom);
      end
      if (disturb && cyc == 6) bus.start = 1'b0;
      @(posedge clk);
      #1;
      cyc++;
      if (bus.done) begin
        seen = 1'b1;
      end else if (cyc == 4) begin
        check("hold_quotient", bus.quotient, prev_q);
        check("hold_remainder", bus.remainder, prev_r);
      end
    end
    check("done_seen", seen, 1);
    check("latency", cyc, exp_lat(d));
    check("quotient", bus.quotient, exp_q(n, d));
    check("remainder", bus.remainder, exp_r(n, d));
`ifdef DIV_DBZ_ERR_EN
    check("dbz", bus.dbz, (d == 0) ? 1 : 0);
`endif
    prev_q = exp_q(n, d);
    prev_r = exp_r(n, d);
    @(posedge clk);
    #1;
    check("done_one_cycle", bus.done, 0);
    if (disturb) begin
      int extra = 0;
      for (int i = 0; i < 12; i++) begin
        @(posedge clk);
        #1;
        if (bus.done) extra++;
      end
      check("no_extra_done", extra, 0);
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_cur, d_cur, gap;
    bit seen;

    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    rst_n        = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_quotient", bus.quotient, 0);
    check("reset_remainder", bus.remainder, 0);
`ifdef DIV_DBZ_ERR_EN
    check("reset_dbz", bus.dbz, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    run_div(100, 7, 1'b0);
    run_div(255, 1, 1'b0);
    run_div(5, 9, 1'b0);
    run_div(200, 200, 1'b0);
    run_div(77, 0, 1'b0);
    run_div(123, 45, 1'b1);

    // Abort mid-iteration with an asynchronous reset.
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 8'd100;
    bus.divisor  = 8'd7;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_quotient", bus.quotient, 0);
    check("abort_remainder", bus.remainder, 0);
    repeat (2) @(posedge clk);
    #1;
    check("abort_no_done", bus.done, 0);
    @(negedge clk);
    rst_n  = 1'b1;
    prev_q = 0;
    prev_r = 0;
    run_div(63, 8, 1'b0);

    // Back-to-back random divisions with start held high.
    n_cur = $urandom_range(0, 255);
    d_cur = ($urandom_range(0, 19) == 0) ? 0 : $urandom_range(1, 255);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = n_cur[WIDTH-1:0];
    bus.divisor  = d_cur[WIDTH-1:0];
    @(posedge clk);
    for (int i = 0; i < 1000; i++) begin
      gap  = 0;
      seen = 1'b0;
      while (!seen && gap < 30) begin
        @(posedge clk);
        #1;
        gap++;
        if (bus.done) seen = 1'b1;
      end
      if (!seen) begin
        check("b2b_done_seen", seen, 1);
        break;
      end
      check("b2b_period", gap, (i == 0) ? exp_lat(d_cur) : exp_lat(d_cur) + 1);
      check("b2b_quotient", bus.quotient, exp_q(n_cur, d_cur));
      check("b2b_remainder", bus.remainder, exp_r(n_cur, d_cur));
      n_cur = $urandom_range(0, 255);
      d_cur = ($urandom_range(0, 19) == 0) ? 0 : $urandom_range(1, 255);
      bus.dividend = n_cur[WIDTH-1:0];
      bus.divisor  = d_cur[WIDTH-1:0];
    end
    bus.start = 1'b0;
    repeat (15) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
